// File: rtl/event_sync_pkg.sv
// Shared sizing helpers and legal parameter ranges for the event_sync_rx block.
package event_sync_pkg;

  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 16;
  localparam int SYNC_MIN     = 2;
  localparam int SYNC_MAX     = 4;
  localparam int CNT_W_MIN    = 1;
  localparam int CNT_W_MAX    = 16;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/event_sync_rx_sync.sv
// One channel's toggle synchronizer: STAGES sync flops, one history flop, and
// a one-cycle pulse per level change of the asynchronous toggle.
module toggle_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic toggle_in,
  output logic pulse
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], toggle_in};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign pulse = sync_q[STAGES-1] ^ hist_q;

endmodule

// File: rtl/event_sync_rx.sv
// Multi-channel toggle event receiver: per-channel sync, saturating event counters,
// round-robin valid/ready delivery, ack toggles. Sticky overflow flags: EVENT_SYNC_OVERFLOW_EN.
module event_sync_rx
  import event_sync_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 4,
  localparam int CH_W        = ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] toggle_in,
  output logic                evt_valid,
  output logic [CH_W-1:0]     evt_chan,
  input  logic                evt_ready,
  output logic [CHANNELS-1:0] ack_toggle,
  output logic [CHANNELS-1:0] pending_nz,
  output logic [CHANNELS-1:0] overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
      SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_param_err
    $error("event_sync_rx: parameter out of range");
  end

  logic [CHANNELS-1:0] pulse, pop, nz;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic                evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]     evt_chan_q, evt_chan_d, ptr_q, ptr_d;
  logic [CHANNELS-1:0] ack_q, ack_d, pnz_q, pnz_d;
  logic                hs;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sync
    toggle_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .toggle_in (toggle_in[gi]),
      .pulse     (pulse[gi])
    );
  end

  always_comb begin
    hs          = evt_valid_q & evt_ready;
    pop         = '0;
    nz          = '0;
    ptr_d       = ptr_q;
    evt_valid_d = evt_valid_q;
    evt_chan_d  = evt_chan_q;
    for (int i = 0; i < CHANNELS; i++) begin
      pop[i]   = hs && (evt_chan_q == CH_W'(i));
      cnt_d[i] = cnt_q[i];
      // A pulse into a full counter is dropped; pulse with pop cancels out.
      if (pulse[i] && !pop[i] && cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (pop[i] && !pulse[i])
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      nz[i] = (cnt_d[i] != '0);
    end
    if (hs)
      ptr_d = (evt_chan_q == CH_W'(CHANNELS - 1)) ? '0 : evt_chan_q + CH_W'(1);
    // Re-select only when the output slot is free, so a stalled event stays put.
    if (!evt_valid_q || hs) begin
      evt_valid_d = |nz;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (nz[(int'(ptr_d) + k) % CHANNELS])
          evt_chan_d = CH_W'((int'(ptr_d) + k) % CHANNELS);
      end
    end
    ack_d = ack_q ^ pop;
    pnz_d = nz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      evt_valid_q <= 1'b0;
      evt_chan_q  <= '0;
      ptr_q       <= '0;
      ack_q       <= '0;
      pnz_q       <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      evt_valid_q <= evt_valid_d;
      evt_chan_q  <= evt_chan_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      pnz_q       <= pnz_d;
    end
  end

`ifdef EVENT_SYNC_OVERFLOW_EN
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < CHANNELS; i++)
      if (pulse[i] && !pop[i] && cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = '0;
`endif

  assign evt_valid  = evt_valid_q;
  assign evt_chan   = evt_chan_q;
  assign ack_toggle = ack_q;
  assign pending_nz = pnz_q;

endmodule

// File: tb/tb_event_sync_rx.sv
// Scenario bench for event_sync_rx: expected channels queued on each toggle,
// popped and compared at every observed handshake.
module tb_event_sync_rx;

  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CHANNELS-1:0] toggle_in = '0;
  logic                evt_ready = 1'b0;
  logic                evt_valid;
  logic [CH_W-1:0]     evt_chan;
  logic [CHANNELS-1:0] ack_toggle, pending_nz, overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];
  logic [CHANNELS-1:0] ack_exp = '0;

  always #5 clk = ~clk;

  event_sync_rx #(.CHANNELS(CHANNELS), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .toggle_in  (toggle_in),
    .evt_valid  (evt_valid),
    .evt_chan   (evt_chan),
    .evt_ready  (evt_ready),
    .ack_toggle (ack_toggle),
    .pending_nz (pending_nz),
    .overflow   (overflow)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flip(input int ch, input bit expect_evt);
    toggle_in[ch] = ~toggle_in[ch];
    if (expect_evt) exp_q.push_back(ch);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(2);
    tests_run++;
    if ({evt_valid, evt_chan} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_valid_chan: got %b/%0d want 0/0", evt_valid, evt_chan);
    end
    tests_run++;
    if ({ack_toggle, pending_nz, overflow} !== 12'h000) begin
      tests_failed++; $display("FAIL reset_vectors: got ack=%b pnz=%b ovf=%b want zeros", ack_toggle, pending_nz, overflow);
    end
    rst = 1'b0;
    cyc(3);
    tests_run++;
    if (evt_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle: got valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_single;
    int e;
    evt_ready = 1'b1;
    flip(2, 1'b1);
    cyc(2);
    tests_run++;
    if (evt_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_early: got valid=%b want 0", evt_valid);
    end
    cyc(1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (evt_valid !== 1'b1 || int'(evt_chan) != e) begin
      tests_failed++; $display("FAIL single_evt: got valid=%b chan=%0d want 1/%0d", evt_valid, evt_chan, e);
    end
    if (evt_valid) ack_exp[evt_chan] = ~ack_exp[evt_chan];
    cyc(1);
    tests_run++;
    if (evt_valid !== 1'b0 || ack_toggle !== ack_exp) begin
      tests_failed++; $display("FAIL single_after: got valid=%b ack=%b want 0/%b", evt_valid, ack_toggle, ack_exp);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int e;
    evt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flip(1, 1'b1);
      cyc(4);
    end
    tests_run++;
    if (pending_nz[1] !== 1'b1 || evt_valid !== 1'b1 || evt_chan !== 2'd1) begin
      tests_failed++; $display("FAIL bp_hold: got pnz1=%b valid=%b chan=%0d want 1/1/1", pending_nz[1], evt_valid, evt_chan);
    end
    cyc(3);
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 2'd1) begin
      tests_failed++; $display("FAIL bp_stable: got valid=%b chan=%0d want 1/1", evt_valid, evt_chan);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      tests_run++;
      if (evt_valid !== 1'b1 || int'(evt_chan) != e) begin
        tests_failed++; $display("FAIL bp_drain%0d: got valid=%b chan=%0d want 1/%0d", k, evt_valid, evt_chan, e);
      end
      if (evt_valid) ack_exp[evt_chan] = ~ack_exp[evt_chan];
      cyc(1);
    end
    tests_run++;
    if (evt_valid !== 1'b0 || ack_toggle !== ack_exp || ack_toggle[1] !== 1'b1 || pending_nz !== 4'b0000) begin
      tests_failed++; $display("FAIL bp_done: got valid=%b ack=%b pnz=%b want 0/%b/0000", evt_valid, ack_toggle, pending_nz, ack_exp);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    int e;
    evt_ready = 1'b0;
    flip(0, 1'b1);
    cyc(1);
    flip(1, 1'b1); flip(2, 1'b1); flip(3, 1'b1);
    cyc(5);
    tests_run++;
    if (pending_nz !== 4'b1111) begin
      tests_failed++; $display("FAIL rr_pending: got %b want 1111", pending_nz);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      tests_run++;
      if (evt_valid !== 1'b1 || int'(evt_chan) != e || e != k) begin
        tests_failed++; $display("FAIL rr_grant%0d: got valid=%b chan=%0d want 1/%0d", k, evt_valid, evt_chan, k);
      end
      if (evt_valid) ack_exp[evt_chan] = ~ack_exp[evt_chan];
      cyc(1);
    end
    tests_run++;
    if (evt_valid !== 1'b0 || ack_toggle !== ack_exp) begin
      tests_failed++; $display("FAIL rr_done: got valid=%b ack=%b want 0/%b", evt_valid, ack_toggle, ack_exp);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_simultaneous;
    int e;
    evt_ready = 1'b0;
    flip(0, 1'b1);
    cyc(5);
    flip(0, 1'b1);
    cyc(2);
    evt_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (evt_valid !== 1'b1 || int'(evt_chan) != e) begin
      tests_failed++; $display("FAIL simul_first: got valid=%b chan=%0d want 1/%0d", evt_valid, evt_chan, e);
    end
    if (evt_valid) ack_exp[evt_chan] = ~ack_exp[evt_chan];
    cyc(1);
    evt_ready = 1'b0;
    tests_run++;
    if (evt_valid !== 1'b1 || evt_chan !== 2'd0 || pending_nz !== 4'b0001) begin
      tests_failed++; $display("FAIL simul_keep: got valid=%b chan=%0d pnz=%b want 1/0/0001", evt_valid, evt_chan, pending_nz);
    end
    cyc(2);
    evt_ready = 1'b1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (evt_valid !== 1'b1 || int'(evt_chan) != e) begin
      tests_failed++; $display("FAIL simul_second: got valid=%b chan=%0d want 1/%0d", evt_valid, evt_chan, e);
    end
    if (evt_valid) ack_exp[evt_chan] = ~ack_exp[evt_chan];
    cyc(1);
    evt_ready = 1'b0;
    tests_run++;
    if (evt_valid !== 1'b0 || ack_toggle !== ack_exp) begin
      tests_failed++; $display("FAIL simul_done: got valid=%b ack=%b want 0/%b", evt_valid, ack_toggle, ack_exp);
    end
  endtask

  task automatic test_saturation;
    int e, n;
    logic [CHANNELS-1:0] ovf_exp;
`ifdef EVENT_SYNC_OVERFLOW_EN
    ovf_exp = 4'b1000;
`else
    ovf_exp = 4'b0000;
`endif
    evt_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      flip(3, 1'b1);
      cyc(4);
    end
    tests_run++;
    if (overflow !== 4'b0000 || pending_nz !== 4'b1000) begin
      tests_failed++; $display("FAIL sat_full: got ovf=%b pnz=%b want 0000/1000", overflow, pending_nz);
    end
    flip(3, 1'b0);
    cyc(4);
    tests_run++;
    if (overflow !== ovf_exp) begin
      tests_failed++; $display("FAIL sat_overflow: got %b want %b", overflow, ovf_exp);
    end
    evt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      if (evt_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        tests_run++;
        if (int'(evt_chan) != e) begin
          tests_failed++; $display("FAIL sat_drain%0d: got chan=%0d want %0d", n, evt_chan, e);
        end
        ack_exp[evt_chan] = ~ack_exp[evt_chan];
        n++;
      end
      cyc(1);
    end
    tests_run++;
    if (n != 15 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL sat_count: got %0d events (%0d unmatched) want 15/0", n, exp_q.size());
    end
    tests_run++;
    if (overflow !== ovf_exp || ack_toggle !== ack_exp) begin
      tests_failed++; $display("FAIL sat_after: got ovf=%b ack=%b want %b/%b", overflow, ack_toggle, ovf_exp, ack_exp);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    evt_ready = 1'b0;
    for (int ch = 1; ch < CHANNELS; ch++)
      if (toggle_in[ch]) flip(ch, 1'b0);
    if (!toggle_in[0]) begin
      flip(0, 1'b0);
    end else begin
      flip(0, 1'b0);
      cyc(4);
      flip(0, 1'b0);
    end
    cyc(4);
    tests_run++;
    if (pending_nz === 4'b0000 || evt_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_pre: got pnz=%b valid=%b want nonzero/1", pending_nz, evt_valid);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({evt_valid, evt_chan, ack_toggle, pending_nz, overflow} !== 15'h0) begin
      tests_failed++; $display("FAIL rstmid_async: got valid=%b chan=%0d ack=%b pnz=%b ovf=%b want zeros",
                               evt_valid, evt_chan, ack_toggle, pending_nz, overflow);
    end
    cyc(2);
    tests_run++;
    if ({evt_valid, ack_toggle, pending_nz} !== 9'h0) begin
      tests_failed++; $display("FAIL rstmid_hold: got valid=%b ack=%b pnz=%b want zeros", evt_valid, ack_toggle, pending_nz);
    end
    exp_q.delete();
    ack_exp = '0;
    exp_q.push_back(0);
    rst = 1'b0;
    evt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (evt_valid) begin
        tests_run++;
        if (exp_q.size() == 0 || int'(evt_chan) != exp_q[0]) begin
          tests_failed++; $display("FAIL rstmid_evt%0d: got chan=%0d want 0 (once)", n, evt_chan);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        ack_exp[evt_chan] = ~ack_exp[evt_chan];
        n++;
      end
      cyc(1);
    end
    tests_run++;
    if (n != 1 || ack_toggle !== ack_exp || ack_toggle !== 4'b0001) begin
      tests_failed++; $display("FAIL rstmid_count: got %0d events ack=%b want 1/0001", n, ack_toggle);
    end
    evt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
